lsu_mem_if: RTL and testbench



---
 rtl/lsu_mem_if_if.sv | 21 ++
 rtl/lsu_mem_if.sv | 78 +++++++
 tb/tb_lsu_mem_if.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_if_if.sv
// lsu_mem_if_if: request/response handshake and BRAM port bundle for the RV32I load/store unit.
interface lsu_mem_if_if #(parameter int DEPTH = 4096, parameter int XLEN = 32);
   localparam int ADDRWIDTH = $clog2(DEPTH);
   logic                 req_valid, req_ready, req_we;
   logic [2:0]           req_funct3;
   logic [XLEN-1:0]      req_addr, req_wdata;
   logic                 rsp_valid, rsp_ready, rsp_err;
   logic [XLEN-1:0]      rsp_rdata;
   logic                 mem_en, mem_wrEn;
   logic [ADDRWIDTH-1:0] mem_addr;
   logic [XLEN-1:0]      mem_dataIn, mem_dataOut;
   logic [3:0]           mem_byte_we;
   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_dataOut,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_wrEn, mem_addr, mem_dataIn, mem_byte_we
   );
   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_dataOut,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_wrEn, mem_addr, mem_dataIn, mem_byte_we
   );
endinterface

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: RV32I load/store front-end for a byte-enabled single-port BRAM.
// Define LSU_MISALIGN_CHECK_EN to flag misaligned halfword/word accesses as errors.
module lsu_mem_if #(
   parameter int DEPTH = 4096,
   parameter int XLEN  = 32
) (
   input logic        clk,
   input logic        rst,
   lsu_mem_if_if.slave bus
);
   localparam int ADDRWIDTH = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t          state, state_nxt;
   logic            accept, legal, misalign, err;
   logic [2:0]      f3_q;
   logic [1:0]      lane_q;
   logic            err_q, we_q;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic [XLEN-1:0] load_data;
   logic            unused_hi;
   assign unused_hi = ^bus.req_addr[XLEN-1:ADDRWIDTH];
   always_comb begin
      legal = bus.req_we ? (bus.req_funct3 <= 3'd2)
                         : (bus.req_funct3[1:0] != 2'd3 && bus.req_funct3 != 3'd6);
`ifdef LSU_MISALIGN_CHECK_EN
      misalign = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
                 (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0);
`else
      misalign = 1'b0;
`endif
      err = !legal || misalign;
      bus.req_ready = state == IDLE && !rst;
      accept = bus.req_ready && bus.req_valid;
      // Illegal requests still run through the FSM but never touch the BRAM.
      bus.mem_en = accept && !err;
      bus.mem_wrEn = bus.mem_en && bus.req_we;
      bus.mem_addr = bus.mem_en ? bus.req_addr[ADDRWIDTH-1:0] : '0;
      bus.mem_dataIn = !bus.mem_wrEn ? '0 :
                       bus.req_funct3[1:0] == 2'd0 ? {4{bus.req_wdata[7:0]}} :
                       bus.req_funct3[1:0] == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
      bus.mem_byte_we = !bus.mem_wrEn ? 4'b0000 :
                        bus.req_funct3[1:0] == 2'd0 ? 4'b0001 << bus.req_addr[1:0] :
                        bus.req_funct3[1:0] == 2'd1 ? (bus.req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      byte_sel = bus.mem_dataOut[{lane_q, 3'b000} +: 8];
      half_sel = lane_q[1] ? bus.mem_dataOut[31:16] : bus.mem_dataOut[15:0];
      load_data = f3_q == 3'd0 ? {{(XLEN-8){byte_sel[7]}}, byte_sel} :
                  f3_q == 3'd4 ? {{(XLEN-8){1'b0}}, byte_sel} :
                  f3_q == 3'd1 ? {{(XLEN-16){half_sel[15]}}, half_sel} :
                  f3_q == 3'd5 ? {{(XLEN-16){1'b0}}, half_sel} : bus.mem_dataOut;
      state_nxt = state == IDLE   ? (accept ? ACCESS : IDLE) :
                  state == ACCESS ? RESP : (bus.rsp_ready ? IDLE : RESP);
      bus.rsp_valid = state == RESP && !rst;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
         f3_q          <= 3'd0;
         lane_q        <= 2'd0;
         err_q         <= 1'b0;
         we_q          <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            f3_q   <= bus.req_funct3;
            lane_q <= bus.req_addr[1:0];
            err_q  <= err;
            we_q   <= bus.req_we;
         end
         if (state == ACCESS) begin
            bus.rsp_rdata <= (err_q || we_q) ? '0 : load_data;
            bus.rsp_err   <= err_q;
         end
      end
   end
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed vector table plus reset/backpressure sequences for lsu_mem_if.
module tb_lsu_mem_if;
   localparam int DEPTH = 4096;
   localparam int XLEN  = 32;
`ifdef LSU_MISALIGN_CHECK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif
   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        en;
      logic [3:0]  bwe;
      logic [31:0] din;
      logic [31:0] rdata;
      logic        err;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [31:0] ram [0:1023];
   vec_t tbl [27];
   always #5 clk = ~clk;
   lsu_mem_if_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();
   lsu_mem_if #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));
   // Read-first BRAM model with one-cycle read latency.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         for (int i = 0; i < 4; i++)
            if (bus.mem_byte_we[i]) ram[bus.mem_addr[11:2]][8*i +: 8] <= bus.mem_dataIn[8*i +: 8];
         bus.mem_dataOut <= ram[bus.mem_addr[11:2]];
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic run(input vec_t t, input int idx);
      @(negedge clk);
      bus.req_we = t.we;
      bus.req_funct3 = t.f3;
      bus.req_addr = t.addr;
      bus.req_wdata = t.wdata;
      bus.req_valid = 1'b1;
      #1;
      chk($sformatf("v%0d req_ready", idx), bus.req_ready, 1);
      chk($sformatf("v%0d mem_en", idx), bus.mem_en, t.en);
      chk($sformatf("v%0d mem_wrEn", idx), bus.mem_wrEn, t.en & t.we);
      chk($sformatf("v%0d mem_byte_we", idx), bus.mem_byte_we, t.bwe);
      if (t.en && t.we) chk($sformatf("v%0d mem_dataIn", idx), bus.mem_dataIn, t.din);
      if (t.en) chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, t.addr & (DEPTH - 1));
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk($sformatf("v%0d access rsp_valid", idx), bus.rsp_valid, 0);
      chk($sformatf("v%0d access req_ready", idx), bus.req_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d rsp_valid", idx), bus.rsp_valid, 1);
      chk($sformatf("v%0d rsp_rdata", idx), bus.rsp_rdata, t.rdata);
      chk($sformatf("v%0d rsp_err", idx), bus.rsp_err, t.err);
      @(posedge clk); #1;
      chk($sformatf("v%0d back to idle", idx), bus.req_ready, 1);
      chk($sformatf("v%0d rsp dropped", idx), bus.rsp_valid, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      bus.mem_dataOut = '0;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_we = 1'b1;
      bus.req_funct3 = 3'd2;
      bus.req_addr = 32'h10;
      bus.req_wdata = 32'hFFFFFFFF;
      tbl[0]  = '{1, 3'd2, 32'h10, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 0};
      tbl[1]  = '{0, 3'd2, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 32'hDEADBEEF, 0};
      tbl[2]  = '{1, 3'd0, 32'h13, 32'h000000A5, 1, 4'b1000, 32'hA5A5A5A5, 32'h0, 0};
      tbl[3]  = '{0, 3'd0, 32'h13, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFA5, 0};
      tbl[4]  = '{0, 3'd4, 32'h13, 32'h0, 1, 4'b0000, 32'h0, 32'h000000A5, 0};
      tbl[5]  = '{0, 3'd5, 32'h12, 32'h0, 1, 4'b0000, 32'h0, 32'h0000A5AD, 0};
      tbl[6]  = '{1, 3'd1, 32'h22, 32'h00008001, 1, 4'b1100, 32'h80018001, 32'h0, 0};
      tbl[7]  = '{0, 3'd1, 32'h22, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFF8001, 0};
      tbl[8]  = '{0, 3'd5, 32'h22, 32'h0, 1, 4'b0000, 32'h0, 32'h00008001, 0};
      tbl[9]  = '{1, 3'd0, 32'h20, 32'h1234567F, 1, 4'b0001, 32'h7F7F7F7F, 32'h0, 0};
      tbl[10] = '{0, 3'd2, 32'h20, 32'h0, 1, 4'b0000, 32'h0, 32'h8001007F, 0};
      tbl[11] = '{0, 3'd0, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFEF, 0};
      tbl[12] = '{0, 3'd4, 32'h11, 32'h0, 1, 4'b0000, 32'h0, 32'h000000BE, 0};
      tbl[13] = '{0, 3'd1, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFBEEF, 0};
      tbl[14] = '{0, 3'd3, 32'h10, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1};
      tbl[15] = '{1, 3'd4, 32'h10, 32'hFFFFFFFF, 0, 4'b0000, 32'h0, 32'h0, 1};
      tbl[16] = '{0, 3'd6, 32'h10, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1};
      tbl[17] = '{1, 3'd3, 32'h10, 32'hFFFFFFFF, 0, 4'b0000, 32'h0, 32'h0, 1};
      tbl[18] = MIS ? '{0, 3'd2, 32'h11, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1}
                    : '{0, 3'd2, 32'h11, 32'h0, 1, 4'b0000, 32'h0, 32'hA5ADBEEF, 0};
      tbl[19] = MIS ? '{0, 3'd1, 32'h23, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1}
                    : '{0, 3'd1, 32'h23, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFF8001, 0};
      tbl[20] = MIS ? '{1, 3'd1, 32'h31, 32'h0000BEEF, 0, 4'b0000, 32'h0, 32'h0, 1}
                    : '{1, 3'd1, 32'h31, 32'h0000BEEF, 1, 4'b0011, 32'hBEEFBEEF, 32'h0, 0};
      tbl[21] = '{1, 3'd2, 32'h10000030, 32'h11223344, 1, 4'b1111, 32'h11223344, 32'h0, 0};
      tbl[22] = '{0, 3'd2, 32'h30, 32'h0, 1, 4'b0000, 32'h0, 32'h11223344, 0};
      tbl[23] = '{0, 3'd0, 32'hFFFFF032, 32'h0, 1, 4'b0000, 32'h0, 32'h00000022, 0};
      tbl[24] = '{1, 3'd2, 32'h14, 32'h80000000, 1, 4'b1111, 32'h80000000, 32'h0, 0};
      tbl[25] = '{0, 3'd1, 32'h16, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFF8000, 0};
      tbl[26] = '{0, 3'd5, 32'h16, 32'h0, 1, 4'b0000, 32'h0, 32'h00008000, 0};
      // Reset: a pending store request must not reach the BRAM.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst req_ready", bus.req_ready, 0);
      chk("rst mem_en", bus.mem_en, 0);
      chk("rst mem_wrEn", bus.mem_wrEn, 0);
      chk("rst mem_byte_we", bus.mem_byte_we, 0);
      chk("rst mem_dataIn", bus.mem_dataIn, 0);
      chk("rst rsp_valid", bus.rsp_valid, 0);
      chk("rst rsp_rdata", bus.rsp_rdata, 0);
      chk("rst rsp_err", bus.rsp_err, 0);
      bus.req_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post-rst req_ready", bus.req_ready, 1);
      for (int i = 0; i < 27; i++) run(tbl[i], i);
      // Backpressure: response held while rsp_ready=0, new requests ignored.
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      bus.req_we = 1'b0;
      bus.req_funct3 = 3'd2;
      bus.req_addr = 32'h10;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_we = 1'b1;
      bus.req_funct3 = 3'd0;
      bus.req_wdata = 32'h00000055;
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp%0d rsp_valid", i), bus.rsp_valid, 1);
         chk($sformatf("bp%0d rsp_rdata", i), bus.rsp_rdata, MIS ? 32'hA5ADBEEF : 32'hA5ADBEEF);
         chk($sformatf("bp%0d req_ready", i), bus.req_ready, 0);
         chk($sformatf("bp%0d mem_en", i), bus.mem_en, 0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp release req_ready", bus.req_ready, 1);
      chk("bp release rsp_valid", bus.rsp_valid, 0);
      // Reset during ACCESS drops the response.
      @(negedge clk);
      bus.req_we = 1'b0;
      bus.req_funct3 = 3'd2;
      bus.req_addr = 32'h20;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst req_ready", bus.req_ready, 0);
      chk("midrst mem_en", bus.mem_en, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("midrst%0d rsp_valid", i), bus.rsp_valid, 0);
      end
      chk("midrst rsp_rdata", bus.rsp_rdata, 0);
      run('{0, 3'd2, 32'h10, 32'h0, 1, 4'b0000, 32'h0, 32'hA5ADBEEF, 0}, 100);
      run('{0, 3'd3, 32'h20, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1}, 101);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
